// File: rtl/sreg_tx.sv
// sreg_tx: serial frame transmitter.
// Frame on q_reg: start (0), DATA_WIDTH data bits LSB first, optional even
// parity bit, stop (1). Each bit is held for BIT_DIV clock cycles.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line idle at 1, d_ready high, waiting for d_valid
// ST_START  | driving the start bit (0)
// ST_DATA   | shifting data bits out LSB first
// ST_PARITY | driving the even-parity bit (skipped if PARITY_EN=0)
// ST_STOP   | driving the stop bit (1)
module sreg_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_DIV    = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] d_reg,
    input  logic                  d_valid,
    output logic                  d_ready,
    output logic                  q_reg,
    output logic                  busy_reg
);

    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_q, par_d;
    logic                  line_q, line_d;
    logic                  busy_q, busy_d;
    logic                  bit_end;

    // Divider terminal count marks the last cycle of the current bit.
    assign bit_end  = (div_q == '0);
    assign d_ready  = (state_q == ST_IDLE);
    assign q_reg    = line_q;
    assign busy_reg = busy_q;

    // State and datapath registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: the line value for the next bit is registered at the
    // bit boundary so q_reg never depends combinationally on an input.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        line_d  = line_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (d_valid) begin
                    state_d = ST_START;
                    shift_d = d_reg;
                    par_d   = ^d_reg;
                    div_d   = DIV_LOAD;
                    line_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    line_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = CNT_LOAD;
                    div_d   = DIV_LOAD;
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    div_d = DIV_LOAD;
                    if (cnt_q == '0) begin
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            line_d  = par_q;
                        end else begin
                            state_d = ST_STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        line_d  = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    line_d  = 1'b1;
                    div_d   = DIV_LOAD;
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    line_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sreg_tx.sv
// Directed bench for sreg_tx: default instance (8 bits, 4 cycles/bit, parity)
// plus a no-parity, one-cycle-per-bit instance.
module tb_sreg_tx;

    logic       clock;
    logic       rstn;
    logic [7:0] d_reg;
    logic       d_valid;
    logic       d_ready;
    logic       q_reg;
    logic       busy_reg;

    logic [7:0] d_reg_np;
    logic       d_valid_np;
    logic       d_ready_np;
    logic       q_np;
    logic       busy_np;

    int  n_cmp;
    int  n_bad;
    time edge_prev;
    time edge_last;

    sreg_tx #(.DATA_WIDTH(8), .BIT_DIV(4), .PARITY_EN(1)) dut (
        .clock    (clock),
        .rstn     (rstn),
        .d_reg    (d_reg),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .q_reg    (q_reg),
        .busy_reg (busy_reg)
    );

    sreg_tx #(.DATA_WIDTH(8), .BIT_DIV(1), .PARITY_EN(0)) dut_np (
        .clock    (clock),
        .rstn     (rstn),
        .d_reg    (d_reg_np),
        .d_valid  (d_valid_np),
        .d_ready  (d_ready_np),
        .q_reg    (q_np),
        .busy_reg (busy_np)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; sends one frame on the default instance and checks
    // every cycle of it plus the idle cycle that follows.
    task automatic run_frame(input string name, input logic [7:0] data,
                             input logic [10:0] exp, input bit toggle,
                             input bit hold_valid, input logic [7:0] next_data);
        d_reg   = data;
        d_valid = 1'b1;
        n_cmp++;
        if (d_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_before: got %b want 1", name, d_ready);
        end
        @(posedge clock);
        edge_prev = edge_last;
        edge_last = $time;
        for (int i = 0; i < 44; i++) begin
            @(negedge clock);
            n_cmp++;
            if (q_reg !== exp[i/4]) begin
                n_bad++;
                $display("FAIL %s q cycle %0d: got %b want %b", name, i, q_reg, exp[i/4]);
            end
            n_cmp++;
            if (busy_reg !== 1'b1 || d_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s busy/ready cycle %0d: got %b/%b want 1/0", name, i, busy_reg, d_ready);
            end
            if (toggle) begin
                d_reg   = ~d_reg;
                d_valid = (i < 43) ? ~d_valid : 1'b0;
            end else if (i == 0) begin
                d_reg   = next_data;
                d_valid = hold_valid;
            end
        end
        @(negedge clock);
        n_cmp++;
        if (q_reg !== 1'b1 || busy_reg !== 1'b0 || d_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s idle_after q/busy/ready: got %b/%b/%b want 1/0/1", name, q_reg, busy_reg, d_ready);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; d_reg = 8'h00; d_valid = 1'b0;
        d_reg_np = 8'h00; d_valid_np = 1'b0;
        edge_prev = 0; edge_last = 0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (q_reg !== 1'b1 || busy_reg !== 1'b0 || d_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset q/busy/ready: got %b/%b/%b want 1/0/1", q_reg, busy_reg, d_ready);
        end
        n_cmp++;
        if (q_np !== 1'b1 || busy_np !== 1'b0 || d_ready_np !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_np q/busy/ready: got %b/%b/%b want 1/0/1", q_np, busy_np, d_ready_np);
        end
        rstn = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            n_cmp++;
            if (q_reg !== 1'b1 || busy_reg !== 1'b0) begin
                n_bad++;
                $display("FAIL idle cycle %0d q/busy: got %b/%b want 1/0", i, q_reg, busy_reg);
            end
        end
    endtask

    task automatic test_frame_a5();
        run_frame("a5", 8'hA5, 11'b10101001010, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_00", 8'h00, 11'b10000000000, 1'b0, 1'b1, 8'hFF);
        run_frame("b2b_ff", 8'hFF, 11'b10111111110, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if ((edge_last - edge_prev) / 10 != 45) begin
            n_bad++;
            $display("FAIL b2b gap: got %0d cycles want 45", (edge_last - edge_prev) / 10);
        end
    endtask

    task automatic test_no_parity();
        logic [9:0] exp;
        exp = 10'b1000000010;
        d_reg_np   = 8'h01;
        d_valid_np = 1'b1;
        n_cmp++;
        if (d_ready_np !== 1'b1) begin
            n_bad++;
            $display("FAIL np ready_before: got %b want 1", d_ready_np);
        end
        @(posedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            d_valid_np = 1'b0;
            n_cmp++;
            if (q_np !== exp[i] || busy_np !== 1'b1) begin
                n_bad++;
                $display("FAIL np cycle %0d q/busy: got %b/%b want %b/1", i, q_np, busy_np, exp[i]);
            end
        end
        @(negedge clock);
        n_cmp++;
        if (d_ready_np !== 1'b1 || q_np !== 1'b1 || busy_np !== 1'b0) begin
            n_bad++;
            $display("FAIL np cycle 11 ready/q/busy: got %b/%b/%b want 1/1/0", d_ready_np, q_np, busy_np);
        end
    endtask

    task automatic test_abort();
        d_reg   = 8'hA5;
        d_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        d_valid = 1'b0;
        repeat (16) @(negedge clock);
        n_cmp++;
        if (q_reg !== 1'b0 || busy_reg !== 1'b1) begin
            n_bad++;
            $display("FAIL abort data bit3 q/busy: got %b/%b want 0/1", q_reg, busy_reg);
        end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (q_reg !== 1'b1 || busy_reg !== 1'b0 || d_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort async q/busy/ready: got %b/%b/%b want 1/0/1", q_reg, busy_reg, d_ready);
        end
        @(negedge clock);
        n_cmp++;
        if (q_reg !== 1'b1 || busy_reg !== 1'b0) begin
            n_bad++;
            $display("FAIL abort held q/busy: got %b/%b want 1/0", q_reg, busy_reg);
        end
        rstn = 1'b1;
        run_frame("abort_3c", 8'h3C, 11'b10001111000, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_data_toggle();
        run_frame("toggle_5a", 8'h5A, 11'b10010110100, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_idle();
        test_frame_a5();
        test_back_to_back();
        test_no_parity();
        test_abort();
        test_data_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sreg_tx.md
SREG_TX -- requirements
Module: sreg_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the parallel word width (>=1).
REQ-002 Parameter BIT_DIV, default 4, sets clock cycles per serial bit (>=1).
REQ-003 Parameter PARITY_EN, default 1, inserts an even-parity bit when 1 and omits it when 0.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  in  1  reset, asynchronous assertion, active-low.
REQ-006 d_reg  in  DATA_WIDTH  parallel word to transmit.
REQ-007 d_valid  in  1  d_reg holds a word to send.
REQ-008 d_ready  out  1  block can accept a word this cycle.
REQ-009 q_reg  out  1  serial line; idle level 1.
REQ-010 busy_reg  out  1  a frame is in progress.

Function
REQ-011 The block shall be a serial transmitter: the sending end of a one-wire frame consumed by a capturing register chain on the far side.
REQ-012 The frame shall be: start bit 0, DATA_WIDTH data bits LSB first, parity bit if PARITY_EN, stop bit 1.
REQ-013 Parity shall be even: the parity bit equals the XOR of all data bits.
REQ-014 The FSM shall have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-015 d_ready shall be 1 exactly when the state is IDLE.
REQ-016 A transfer shall occur on a rising edge with d_valid=1 and d_ready=1; d_reg is captured into an internal shift register at that edge.
REQ-017 On the edge after a transfer, the state shall be START, q_reg 0, busy_reg 1.
REQ-018 Each bit shall drive q_reg for exactly BIT_DIV cycles, timed by a divider counter that reloads at each bit boundary.
REQ-019 The data-bit counter shall count DATA_WIDTH bits, then move to PARITY (or STOP) with no gap cycle.
REQ-020 After the last STOP cycle the state shall return to IDLE; for transfer edge t, the frame occupies cycles t+1 .. t+N*BIT_DIV, with N = DATA_WIDTH+2+PARITY_EN.
REQ-021 d_ready shall reassert at cycle t+N*BIT_DIV+1, giving a minimum of one idle cycle (q_reg=1) between frames.
REQ-022 d_reg and d_valid changes while not in IDLE shall have no effect on the frame in progress.
REQ-023 In IDLE with d_valid=0, q_reg shall stay 1 and busy_reg 0 indefinitely.
REQ-024 q_reg and busy_reg shall be driven directly from flops, with no combinational path from any input.
REQ-025 BIT_DIV=1 shall produce one cycle per bit with no skipped or repeated bits.

Reset
REQ-026 While rstn=0: state IDLE, q_reg=1, busy_reg=0, d_ready=1, all counters and the shift register 0.
REQ-027 Assertion of rstn mid-frame shall abort the frame immediately (asynchronously); q_reg returns to 1 with no stop bit sent.
REQ-028 The first transfer shall be accepted no earlier than the first rising edge after rstn deasserts.

Verification
REQ-029 DATA_WIDTH=8, BIT_DIV=4, PARITY_EN=1; send 0xA5 -> q_reg bit sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles in total, busy_reg 1 throughout.
REQ-030 d_valid held at 1 with 0x00 then 0xFF -> second transfer exactly 45 cycles after the first; 0xFF frame bits 0, eight 1s, parity 0, stop 1.
REQ-031 PARITY_EN=0, BIT_DIV=1, send 0x01 -> q_reg 0,1,0,0,0,0,0,0,0,1 over 10 cycles, d_ready high at cycle 11.
REQ-032 rstn pulsed low during data bit 3 -> q_reg=1, busy_reg=0, d_ready=1 asynchronously; a new word 0x3C afterwards produces a clean, complete frame.
REQ-033 d_reg toggled every cycle during a frame of 0x5A -> transmitted bits match 0x5A only.
REQ-034 d_valid=0 for 100 cycles after reset -> q_reg constant 1, busy_reg constant 0.
